mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store) of the 5-stage MIPS pipeline.
- A fixed-latency memory sits behind the arbiter.
- Each pipeline stage stalls while its request is pending and resumes on its ack pulse.
- Data wins by default; a streak limit prevents fetch starvation.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the mem_en cycle to mem_rdata valid; legal range 1..15.
- DM_BURST, 4, max consecutive data grants while if_req is pending.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle.
- if_rdata  out  DATA_W  fetched instruction.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_ack  out  1  one-cycle pulse.
- dm_rdata  out  DATA_W  load data; 0 for stores.
- mem_en  out  1  memory access strobe, one cycle.
- mem_we  out  1  memory write enable, valid with mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  valid MEM_LAT cycles after the mem_en cycle.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; streak counter 0; latched request fields 0.

States:
- IDLE: choose a winner among pending requests.
  - On a winner: latch id, addr, we, wdata; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle): mem_en=1 and mem_we/mem_addr/mem_wdata from the latched fields; load cnt=MEM_LAT; go to WAIT.
- WAIT: decrement cnt each cycle.
  - When cnt==1, capture mem_rdata (forced to 0 for writes) into the response register and go to RESP.
  - This makes WAIT exactly MEM_LAT cycles.
- RESP (1 cycle): pulse the winner's ack; its rdata output holds the captured value; go to IDLE.
  - The loser's ack stays 0.
  - rdata outputs hold their last value between acks.

Timing:
- A request first seen in IDLE at cycle R gets ISSUE at R+1 and ack at R+MEM_LAT+2; IDLE returns at R+MEM_LAT+3.
- MEM_LAT=2: ack at R+4; back-to-back accesses take 5 cycles each.

Arbitration (evaluated in IDLE only):
- Only dm_req: grant DM.
- Only if_req: grant IF.
- Both: grant DM, unless streak==DM_BURST, in which case grant IF.

Streak counter:
- On a DM grant with if_req high, streak increments, saturating at DM_BURST.
- On an IF grant, or a DM grant with if_req low, streak goes to 0.

Requester contract:
- req, addr, we and wdata are stable from assertion until ack.
- In the cycle after ack, req may drop or present a new request.
- The arbiter samples only in IDLE, which is one cycle after RESP, so a held req is never double-served.
- A request that arrives or changes while the arbiter is busy is seen at the next IDLE.

Boundary conditions:
- MEM_LAT=1: WAIT lasts one cycle.
- rst mid-operation: return to IDLE immediately; mem_en and acks drop; any in-flight read is discarded and no ack is produced. A write whose mem_en has already been issued is not retracted.
- Simultaneous rst and req: reset wins; the request is served after reset releases, if still held.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - requester id constants REQ_IF=0, REQ_DM=1;
  - counter width constant CNT_W=4.
- No sub-module is needed: FSM, streak counter and latch registers live in one module.

Test Plan:
- Single fetch: MEM_LAT=2; if_req=1, if_addr=0x40 at cycle 0 (IDLE); memory returns 0x8C010004 → mem_en=1 with mem_addr=0x40 at cycle 1; if_ack=1 with if_rdata=0x8C010004 at cycle 4 only.
- Store: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF → mem_we=1, mem_wdata=0xDEADBEEF at cycle 1; dm_ack=1 with dm_rdata=0 at cycle 4.
- Collision: if_req and dm_req rise in the same IDLE cycle, dm load of 0x200 → DM served first (ack cycle 4); IF ISSUE at cycle 6, if_ack at cycle 9.
- Starvation guard: DM_BURST=4; dm_req and if_req held high continuously, dm issuing a new request after each ack → grant order DM, DM, DM, DM, IF, DM; streak returns to 0 after the IF grant.
- Reset mid-access: rst=1 during WAIT of a load → next cycle state IDLE, busy=0, no dm_ack ever for that load; a held dm_req is re-issued (mem_en) 1 cycle after rst deasserts.
- MEM_LAT=1 sweep: back-to-back fetches at addresses 0x0, 0x4, 0x8 → acks every 4 cycles with correct data; mem_en never asserted in two consecutive cycles.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Requester ids carried with the latched request.
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    // Width of the latency and streak counters (covers MEM_LAT up to 15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between the fetch (IF)
// and data (MEM) pipeline stages. Data wins by default; a streak counter
// hands the port to a waiting fetch after DM_BURST consecutive data grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 2,
    parameter int DM_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(DM_BURST);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    streak_q, streak_d;
    logic                id_q, id_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic [DATA_W-1:0]   rsp_data;
    logic                starve;

    // A fetch that has watched DM_BURST data grants in a row takes the port.
    assign starve   = if_req_i && (streak_q == BURST_C);
    // Stores return zero on the data read port.
    assign rsp_data = we_q ? '0 : mem_rdata_i;

    // Next-state, grant and capture logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        id_d       = id_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (dm_req_i && !starve) begin
                    id_d     = REQ_DM;
                    we_d     = dm_we_i;
                    addr_d   = dm_addr_i;
                    wdata_d  = dm_wdata_i;
                    // starve is false here, so streak_q < DM_BURST when if_req_i.
                    streak_d = if_req_i ? streak_q + 1'b1 : '0;
                    state_d  = ISSUE;
                end else if (if_req_i) begin
                    id_d     = REQ_IF;
                    we_d     = 1'b0;
                    addr_d   = if_addr_i;
                    wdata_d  = '0;
                    streak_d = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_C;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // cnt==1 is the cycle mem_rdata is valid for this access.
                if (cnt_q == CNT_W'(1)) begin
                    if (id_q == REQ_DM) dm_rdata_d = rsp_data;
                    else                if_rdata_d = rsp_data;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            streak_q   <= '0;
            id_q       <= REQ_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            id_q       <= id_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_en_o    = (state_q == ISSUE);
    assign mem_we_o    = mem_en_o && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_ack_o    = (state_q == RESP) && (id_q == REQ_IF);
    assign dm_ack_o    = (state_q == RESP) && (id_q == REQ_DM);
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run scored
// against a transaction-level timing/arbitration model.
module tb_mem_port_arbiter;

    localparam int LAT0  = 2;
    localparam int LAT1  = 1;
    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // DUT0 (MEM_LAT=2)
    logic        if_req = 0, dm_req = 0, dm_we = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
    logic        if_ack, dm_ack, mem_en, mem_we, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

    // DUT1 (MEM_LAT=1), fetch-only traffic
    logic        if_req1 = 0, dm_req1 = 0, dm_we1 = 0;
    logic [31:0] if_addr1 = 0, dm_addr1 = 0, dm_wdata1 = 0;
    logic        if_ack1, dm_ack1, mem_en1, mem_we1, busy1;
    logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT0), .DM_BURST(BURST)) u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy));

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1), .DM_BURST(BURST)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req1), .if_addr_i(if_addr1), .if_ack_o(if_ack1), .if_rdata_o(if_rdata1),
        .dm_req_i(dm_req1), .dm_we_i(dm_we1), .dm_addr_i(dm_addr1), .dm_wdata_i(dm_wdata1),
        .dm_ack_o(dm_ack1), .dm_rdata_o(dm_rdata1),
        .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1),
        .mem_rdata_i(mem_rdata1), .busy_o(busy1));

    // Power-on contents of the memory; 0x40 holds the fetch test instruction.
    function automatic logic [31:0] init_val(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C01_0004;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model for DUT0: data valid MEM_LAT cycles after mem_en, junk otherwise.
    logic [31:0] mem_a [4096];
    bit          mem_w [4096];
    logic [31:0] pipe0 [LAT0];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_a[mem_addr[13:2]] <= mem_wdata;
            mem_w[mem_addr[13:2]] <= 1'b1;
        end
        pipe0[0] <= (mem_en && !mem_we) ?
                    (mem_w[mem_addr[13:2]] ? mem_a[mem_addr[13:2]] : init_val(mem_addr)) : $urandom();
        for (int k = 1; k < LAT0; k++) pipe0[k] <= pipe0[k-1];
    end
    assign mem_rdata = pipe0[LAT0-1];

    // Memory model for DUT1 (read-only, one cycle).
    logic [31:0] pipe1;
    always @(posedge clk) pipe1 <= (mem_en1 && !mem_we1) ? init_val(mem_addr1) : $urandom();
    assign mem_rdata1 = pipe1;

    // Reference shadow memory for the randomized model.
    logic [31:0] ref_mem [4096];
    bit          ref_w   [4096];
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_w[a[13:2]] ? ref_mem[a[13:2]] : init_val(a);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1; if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0;
        if_req1 = 0; if_addr1 = 0;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // Reset state, and a request held across reset is served after release.
    task automatic test_reset();
        @(negedge clk);
        rst = 1; if_req = 1; if_addr = 32'hABC; dm_req = 1; dm_we = 0; dm_addr = 32'h44;
        repeat (2) @(negedge clk);
        n_chk++; if ({mem_en, mem_we, if_ack, dm_ack, busy} !== 5'b0)
            begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_en, mem_we, if_ack, dm_ack, busy}); end
        n_chk++; if (mem_addr !== 0 || mem_wdata !== 0)
            begin n_fail++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wdata); end
        n_chk++; if (if_rdata !== 0 || dm_rdata !== 0)
            begin n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, dm_rdata); end
        n_chk++; if ({mem_en1, if_ack1, dm_ack1, busy1} !== 4'b0 || if_rdata1 !== 0)
            begin n_fail++; $display("FAIL reset_dut1: got %b/%h expected 0000/0", {mem_en1, if_ack1, dm_ack1, busy1}, if_rdata1); end
        rst = 0;
        @(negedge clk);
        n_chk++; if (mem_en !== 1'b1 || mem_addr !== 32'h44)
            begin n_fail++; $display("FAIL reset_release_issue: got en=%b addr=%h expected en=1 addr=00000044", mem_en, mem_addr); end
        repeat (3) @(negedge clk);
        n_chk++; if (dm_ack !== 1'b1 || dm_rdata !== init_val(32'h44) || if_ack !== 1'b0)
            begin n_fail++; $display("FAIL reset_release_ack: got ack=%b data=%h expected ack=1 data=%h", dm_ack, dm_rdata, init_val(32'h44)); end
        dm_req = 0; if_req = 0;
    endtask

    task automatic test_single_fetch();
        do_reset();
        if_req = 1; if_addr = 32'h40;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_chk++; if (mem_en !== (c == 1))
                begin n_fail++; $display("FAIL fetch_mem_en c%0d: got %b expected %b", c, mem_en, c == 1); end
            if (c == 1) begin
                n_chk++; if (mem_addr !== 32'h40 || mem_we !== 1'b0)
                    begin n_fail++; $display("FAIL fetch_issue: got addr=%h we=%b expected 00000040/0", mem_addr, mem_we); end
            end
            n_chk++; if (if_ack !== (c == 4) || dm_ack !== 1'b0)
                begin n_fail++; $display("FAIL fetch_ack c%0d: got if=%b dm=%b expected if=%b dm=0", c, if_ack, dm_ack, c == 4); end
            if (c == 4) begin
                n_chk++; if (if_rdata !== 32'h8C01_0004)
                    begin n_fail++; $display("FAIL fetch_data: got %h expected 8c010004", if_rdata); end
                if_req = 0;
            end
        end
        n_chk++; if (busy !== 1'b0 || if_rdata !== 32'h8C01_0004)
            begin n_fail++; $display("FAIL fetch_hold: got busy=%b data=%h expected 0/8c010004", busy, if_rdata); end
    endtask

    task automatic test_store();
        do_reset();
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_chk++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF)
                    begin n_fail++; $display("FAIL store_issue: got en=%b we=%b addr=%h wd=%h expected 1/1/100/deadbeef", mem_en, mem_we, mem_addr, mem_wdata); end
            end
            n_chk++; if (dm_ack !== (c == 4))
                begin n_fail++; $display("FAIL store_ack c%0d: got %b expected %b", c, dm_ack, c == 4); end
            if (c == 4) begin
                n_chk++; if (dm_rdata !== 32'h0)
                    begin n_fail++; $display("FAIL store_rdata: got %h expected 0", dm_rdata); end
                dm_req = 0; dm_we = 0;
            end
        end
        n_chk++; if (mem_a[32'h100 >> 2] !== 32'hDEAD_BEEF)
            begin n_fail++; $display("FAIL store_mem: got %h expected deadbeef", mem_a[32'h100 >> 2]); end
    endtask

    task automatic test_collision();
        do_reset();
        if_req = 1; if_addr = 32'h300; dm_req = 1; dm_we = 0; dm_addr = 32'h200;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            n_chk++; if (mem_en !== (c == 1 || c == 6))
                begin n_fail++; $display("FAIL coll_mem_en c%0d: got %b expected %b", c, mem_en, c == 1 || c == 6); end
            if (c == 1 || c == 6) begin
                n_chk++; if (mem_addr !== (c == 1 ? 32'h200 : 32'h300))
                    begin n_fail++; $display("FAIL coll_addr c%0d: got %h expected %h", c, mem_addr, c == 1 ? 32'h200 : 32'h300); end
            end
            n_chk++; if (dm_ack !== (c == 4) || if_ack !== (c == 9))
                begin n_fail++; $display("FAIL coll_ack c%0d: got dm=%b if=%b expected dm=%b if=%b", c, dm_ack, if_ack, c == 4, c == 9); end
            if (c == 4) begin
                n_chk++; if (dm_rdata !== init_val(32'h200))
                    begin n_fail++; $display("FAIL coll_dm_data: got %h expected %h", dm_rdata, init_val(32'h200)); end
                dm_req = 0;
            end
            if (c == 9) begin
                n_chk++; if (if_rdata !== init_val(32'h300))
                    begin n_fail++; $display("FAIL coll_if_data: got %h expected %h", if_rdata, init_val(32'h300)); end
                if_req = 0;
            end
        end
    endtask

    task automatic test_starvation();
        bit exp_if [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int ng = 0;
        do_reset();
        if_req = 1; if_addr = 32'h80; dm_req = 1; dm_we = 0; dm_addr = 32'h1000;
        for (int c = 1; c <= 80 && ng < 10; c++) begin
            @(negedge clk);
            if (mem_en) begin
                n_chk++; if ((mem_addr == 32'h80) !== exp_if[ng])
                    begin n_fail++; $display("FAIL starve_order grant%0d: got if=%b expected if=%b", ng, mem_addr == 32'h80, exp_if[ng]); end
                ng++;
            end
            if (dm_ack) dm_addr = dm_addr + 32'h4;
        end
        n_chk++; if (ng != 10)
            begin n_fail++; $display("FAIL starve_timeout: got %0d grants expected 10", ng); end
        if_req = 0; dm_req = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        dm_req = 1; dm_we = 0; dm_addr = 32'h240;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            n_chk++; if (mem_en !== (c == 1 || c == 4))
                begin n_fail++; $display("FAIL rstmid_mem_en c%0d: got %b expected %b", c, mem_en, c == 1 || c == 4); end
            n_chk++; if (dm_ack !== (c == 7))
                begin n_fail++; $display("FAIL rstmid_ack c%0d: got %b expected %b", c, dm_ack, c == 7); end
            if (c == 3) begin
                n_chk++; if (busy !== 1'b0)
                    begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
                rst = 0;
            end
            if (c == 7) begin
                n_chk++; if (dm_rdata !== init_val(32'h240))
                    begin n_fail++; $display("FAIL rstmid_data: got %h expected %h", dm_rdata, init_val(32'h240)); end
                dm_req = 0;
            end
            if (c == 2) rst = 1;
        end
    endtask

    task automatic test_lat1();
        logic prev_en = 1'b0;
        do_reset();
        if_req1 = 1; if_addr1 = 32'h0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            n_chk++; if (mem_en1 !== (c == 1 || c == 5 || c == 9))
                begin n_fail++; $display("FAIL lat1_mem_en c%0d: got %b expected %b", c, mem_en1, c == 1 || c == 5 || c == 9); end
            if (c == 1 || c == 5 || c == 9) begin
                n_chk++; if (mem_addr1 !== if_addr1 || mem_we1 !== 1'b0)
                    begin n_fail++; $display("FAIL lat1_issue c%0d: got %h/%b expected %h/0", c, mem_addr1, mem_we1, if_addr1); end
            end
            n_chk++; if (prev_en && mem_en1)
                begin n_fail++; $display("FAIL lat1_en_consec c%0d: got 1 expected 0", c); end
            prev_en = mem_en1;
            n_chk++; if (if_ack1 !== (c == 3 || c == 7 || c == 11) || dm_ack1 !== 1'b0)
                begin n_fail++; $display("FAIL lat1_ack c%0d: got %b/%b expected %b/0", c, if_ack1, dm_ack1, c == 3 || c == 7 || c == 11); end
            if (c == 3 || c == 7 || c == 11) begin
                n_chk++; if (if_rdata1 !== init_val(if_addr1))
                    begin n_fail++; $display("FAIL lat1_data c%0d: got %h expected %h", c, if_rdata1, init_val(if_addr1)); end
                if_addr1 = if_addr1 + 32'h4;
                if (c == 11) if_req1 = 0;
            end
        end
        n_chk++; if (busy1 !== 1'b0 || dm_rdata1 !== 32'h0)
            begin n_fail++; $display("FAIL lat1_idle: got busy=%b dmr=%h expected 0/0", busy1, dm_rdata1); end
    endtask

    // Randomized traffic: the model decides each grant from the arbitration
    // rules and predicts issue/ack cycles from the fixed access timing.
    task automatic test_random();
        int next_dec = 0, issue_cyc = -1, ack_cyc = -1, streak = 0;
        bit win_dm = 0, exp_we = 0;
        logic [31:0] exp_addr = 0, exp_wdata = 0, exp_data = 0, last_if = 0, last_dm = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            n_chk++; if (mem_en !== (c == issue_cyc))
                begin n_fail++; $display("FAIL rand_mem_en c%0d: got %b expected %b", c, mem_en, c == issue_cyc); end
            if (c == issue_cyc) begin
                n_chk++; if (mem_addr !== exp_addr || mem_we !== exp_we || (exp_we && mem_wdata !== exp_wdata))
                    begin n_fail++; $display("FAIL rand_issue c%0d: got %h/%b/%h expected %h/%b/%h", c, mem_addr, mem_we, mem_wdata, exp_addr, exp_we, exp_wdata); end
            end
            if (c == ack_cyc) begin
                if (win_dm) last_dm = exp_data; else last_if = exp_data;
            end
            n_chk++; if (if_ack !== (c == ack_cyc && !win_dm) || dm_ack !== (c == ack_cyc && win_dm))
                begin n_fail++; $display("FAIL rand_ack c%0d: got if=%b dm=%b expected if=%b dm=%b", c, if_ack, dm_ack, c == ack_cyc && !win_dm, c == ack_cyc && win_dm); end
            n_chk++; if (if_rdata !== last_if || dm_rdata !== last_dm)
                begin n_fail++; $display("FAIL rand_rdata c%0d: got %h/%h expected %h/%h", c, if_rdata, dm_rdata, last_if, last_dm); end
            // requesters: drop on ack, then maybe raise a fresh request
            if (c == ack_cyc) begin
                if (win_dm) dm_req = 0; else if_req = 0;
            end
            if (!if_req && $urandom_range(0, 1) == 0) begin
                if_req = 1; if_addr = 32'($urandom_range(0, 15) * 4);
            end
            if (!dm_req && $urandom_range(0, 3) != 0) begin
                dm_req = 1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = 32'($urandom_range(0, 15) * 4); dm_wdata = $urandom();
            end
            // model: arbitration only at the predicted idle cycle
            if (c == next_dec) begin
                if (dm_req && !(if_req && streak == BURST)) begin
                    win_dm = 1; exp_addr = dm_addr; exp_we = dm_we; exp_wdata = dm_wdata;
                    exp_data = dm_we ? 32'h0 : ref_rd(dm_addr);
                    if (dm_we) begin ref_mem[dm_addr[13:2]] = dm_wdata; ref_w[dm_addr[13:2]] = 1; end
                    streak = if_req ? ((streak < BURST) ? streak + 1 : BURST) : 0;
                end else if (if_req) begin
                    win_dm = 0; exp_addr = if_addr; exp_we = 0; exp_data = ref_rd(if_addr);
                    streak = 0;
                end
                if (dm_req || if_req) begin
                    issue_cyc = c + 1; ack_cyc = c + LAT0 + 2; next_dec = c + LAT0 + 3;
                end else begin
                    next_dec = c + 1;
                end
            end
            @(negedge clk);
        end
        if_req = 0; dm_req = 0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_collision();
        test_starvation();
        test_reset_mid();
        test_lat1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
